uart_tx_cfg: RTL
================

# uart_tx_cfg

Parametrised, buffered UART transmitter and successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into a small FIFO and serialises them onto `ftdi_txd`. Frames run back-to-back with no idle gap. Data width, parity, stop-bit count, baud rate and FIFO depth are all configurable. The block sits between on-chip producers and the FTDI serial pin on the ULX3S.

## Interface
- `CLK_HZ`, 25_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate. `CYCLES = (CLK_HZ + BAUD/2) / BAUD`, i.e. the divisor rounded to nearest. Must be at least 2.
- `DATA_BITS`, 8: payload bits per frame, range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries, a power of 2 and at least 2.

Ports:
- `clk_25mhz`, in, 1: the single clock for the block.
- `reset`, in, 1: asynchronous, active-high.
- `tx_data`, in, `DATA_BITS`: word to send.
- `tx_valid`, in, 1: producer offers `tx_data`.
- `tx_ready`, out, 1: FIFO not full.
- `ftdi_txd`, out, 1: serial line, registered, idles high.
- `tx_busy`, out, 1: high while in any state other than IDLE.
- `frame_done`, out, 1: one-cycle pulse in the last clock of the final stop bit.
- `fifo_count`, out, `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- **Push:** a word is pushed on a clock edge when `tx_valid && tx_ready`. `tx_ready` is combinational and equals `fifo_count != FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `ftdi_txd` = 1.
  - If the FIFO is non-empty: pop the head into the shift register, clear the bit counter and baud counter, and go to START.
- **START:** `ftdi_txd` = 0 for `CYCLES` clocks, then go to DATA.
- **DATA:** send LSB first, each bit for `CYCLES` clocks, `DATA_BITS` bits total. After the last bit, go to PARITY if `PARITY != 0`, otherwise to STOP.
- **PARITY:**
  - Even: bit = XOR of the data bits.
  - Odd: bit = inverted XOR of the data bits.
  - The bit lasts `CYCLES` clocks.
- **STOP:** `ftdi_txd` = 1 for `STOP_BITS*CYCLES` clocks. In the final clock:
  - `frame_done` = 1.
  - If the FIFO is non-empty, pop and go straight to START, so the next start bit begins on the following clock.
  - Otherwise go to IDLE.
- **Baud counter:**
  - Counts 0..`CYCLES-1` and ticks at `CYCLES-1`.
  - It is restarted at every frame start rather than free-running, so every bit is exactly `CYCLES` clocks.
- **Frame length:** `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CYCLES` clocks.
- **Simultaneous push and pop:**
  - `fifo_count` is unchanged.
  - The popped word is the old head.
  - A push into an empty FIFO is never popped in the same cycle.
- **Full FIFO:** `tx_ready` = 0 and the push is ignored. A pop frees the slot, and `tx_ready` rises the next cycle.
- **FIFO storage:** read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally.
- **Reset (asynchronous, any time, including mid-frame):**
  - FSM goes to IDLE and the FIFO is emptied.
  - `ftdi_txd` = 1 immediately, truncating the frame.
  - `tx_busy` = 0, `frame_done` = 0, `fifo_count` = 0.
  - `tx_ready` = 1.
  - Pushes while `reset` is high are discarded.

## Timing
- **Latency:** push at edge N into an empty FIFO while IDLE:
  - `fifo_count` = 1 after N.
  - Pop at N+1.
  - `ftdi_txd` falls after edge N+2.
- **Back-to-back frames:** zero idle clocks between the stop bit and the next start bit.
- **`frame_done`:** asserts in the same cycle as the last stop-bit clock and never for truncated frames.
- **`tx_busy`:** rises with the START entry and falls on the IDLE entry.

## Test plan
- **Single 8N1 frame:** `BAUD`=115200 (`CYCLES`=217), push 0x55.
  - `ftdi_txd` sequence: 0, 1,0,1,0,1,0,1,0, 1, each bit 217 clocks.
  - One `frame_done`.
  - Frame = 2170 clocks.
- **Parity:** push 0xA5 (four ones).
  - `PARITY`=2 gives parity bit 0.
  - `PARITY`=1 gives parity bit 1.
  - Frame = 11×`CYCLES`.
- **7-bit data, 2 stop bits:** `DATA_BITS`=7, `STOP_BITS`=2, push 0x41.
  - Bits 1,0,0,0,0,0,1 LSB-first.
  - High for 2×`CYCLES`.
  - `frame_done` in the final stop clock only.
- **FIFO fill and overflow:** hold `tx_valid` high with 6 words while the first frame is sending, `FIFO_DEPTH`=4.
  - `tx_ready` drops when `fifo_count`=4 and the extra push is held off.
  - All words are sent in order with zero inter-frame gap.
- **Simultaneous push/pop:** push at the exact clock of a STOP-to-START pop with `fifo_count`=2.
  - `fifo_count` stays 2.
  - Order is preserved.
- **Mid-frame reset:** assert `reset` mid-DATA with 3 words queued.
  - `ftdi_txd` = 1 immediately.
  - `fifo_count` = 0, no `frame_done`.
  - A push after release produces a clean frame with 2-clock latency.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered, parametrised UART transmitter.
//
// Words are accepted into a small FIFO and serialised onto ftdi_txd as
// start bit, DATA_BITS data bits (LSB first), optional parity bit and
// STOP_BITS stop bits. Every bit lasts CYCLES clocks, where CYCLES is
// CLK_HZ/BAUD rounded to nearest. Frames run back-to-back with no idle gap.
//
// Ports:
//   clk_25mhz   in   single clock
//   reset       in   asynchronous, active-high; empties the FIFO, idles the line
//   tx_data     in   word to send (DATA_BITS wide)
//   tx_valid    in   producer offers tx_data
//   tx_ready    out  FIFO not full (combinational)
//   ftdi_txd    out  registered serial line, idles high
//   tx_busy     out  FSM is not in IDLE
//   frame_done  out  one-cycle pulse in the last clock of the final stop bit
//   fifo_count  out  current FIFO occupancy
//   fsm_state_o out  raw FSM state for observation
//
// Handshake: a word transfers on a rising clock edge where tx_valid and
// tx_ready are both high; tx_ready depends only on the FIFO occupancy, never
// on tx_valid, and a producer may hold tx_valid high across stalled cycles.
module uart_tx_cfg #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_25mhz,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          ftdi_txd,
   output logic                          tx_busy,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    fsm_state_o
);

   localparam int CYCLES = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int BAUD_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 txd_q;
   logic                 done_q;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 tick;
   logic                 last_data;
   logic                 last_stop;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;

   assign tick       = (baud_q == BAUD_W'(CYCLES - 1));
   assign last_data  = (bit_q == 4'(DATA_BITS - 1));
   assign last_stop  = (bit_q == 4'(STOP_BITS - 1));
   assign fifo_empty = (count_q == '0);
   assign tx_ready   = (count_q != CNT_W'(FIFO_DEPTH));
   assign push       = tx_valid && tx_ready;
   // Pops happen from IDLE, or in the final stop clock so the next start bit
   // follows with no gap. Emptiness is the registered count, so a word pushed
   // into an empty FIFO is never popped in the same cycle.
   assign pop        = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && tick && last_stop));
   assign head       = mem_q[rd_ptr_q];
   // Even parity is the XOR of the data bits; odd parity is its inverse.
   assign head_par   = (^head) ^ (PARITY == 1);

   // ---------------- FIFO ----------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_25mhz) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

   // ---------------- Transmit FSM ----------------
   // ftdi_txd is registered from the current state, so the line trails the
   // state by one clock; frame_done is registered the same way and therefore
   // lands in the last clock of the final stop bit as seen on the line.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= head;
                  par_q   <= head_par;
                  bit_q   <= '0;
                  baud_q  <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               txd_q <= 1'b0;
               if (tick) begin
                  baud_q  <= '0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               txd_q <= shift_q[0];
               if (tick) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  if (last_data) begin
                     bit_q   <= '0;
                     state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_PARITY: begin
               txd_q <= par_q;
               if (tick) begin
                  baud_q  <= '0;
                  state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               txd_q <= 1'b1;
               if (tick) begin
                  baud_q <= '0;
                  if (last_stop) begin
                     done_q <= 1'b1;
                     bit_q  <= '0;
                     if (pop) begin
                        shift_q <= head;
                        par_q   <= head_par;
                        state_q <= S_START;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ftdi_txd    = txd_q;
   assign frame_done  = done_q;
   assign tx_busy     = (state_q != S_IDLE);
   assign fifo_count  = count_q;
   assign fsm_state_o = state_q;

endmodule
